// File: rtl/seg7_scan_display_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | seg7_scan_display_if: CPU output-port bus feeding the display    |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
interface seg7_scan_display_if;
  logic [15:0] out_data;
  logic        out_valid;
  logic        halted;

  modport master (output out_data, output out_valid, output halted);
  modport slave  (input  out_data, input  out_valid, input  halted);
endinterface
`default_nettype wire

// File: rtl/seg7_scan_display.sv
`default_nettype none
// +------------------------------------------------------------------+
// | seg7_scan_display: latches CPU output, scans it onto 4 hex digits |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module seg7_scan_display #(
  parameter int REFRESH_DIV = 50000,
  parameter int GUARD       = 16,
  parameter int BLANK_LZ    = 1,
  parameter int ACTIVE_LOW  = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  seg7_scan_display_if.slave  cpu,
  output logic [6:0]          seg,
  output logic                dp,
  output logic [3:0]          an,
  output logic [15:0]         shown
);

  localparam int              CNT_W     = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_GUARD = CNT_W'(GUARD);
  localparam logic            POL       = (ACTIVE_LOW != 0);
  localparam logic [6:0]      SEG_OFF   = {7{POL}};
  localparam logic [3:0]      AN_OFF    = {4{POL}};

  typedef enum logic [0:0] {ST_OFF = 1'b0, ST_SCAN = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       idx_q, idx_d;
  logic [15:0]      shown_q, shown_d;
  logic [6:0]       seg_q, seg_d;
  logic             dp_q, dp_d;
  logic [3:0]       an_q, an_d;

  logic [3:0]       nibble;
  logic             blank;
  logic             lit;

  function automatic logic [6:0] hex_font(input logic [3:0] n);
    case (n)
      4'h0: hex_font = 7'h3F;  4'h1: hex_font = 7'h06;
      4'h2: hex_font = 7'h5B;  4'h3: hex_font = 7'h4F;
      4'h4: hex_font = 7'h66;  4'h5: hex_font = 7'h6D;
      4'h6: hex_font = 7'h7D;  4'h7: hex_font = 7'h07;
      4'h8: hex_font = 7'h7F;  4'h9: hex_font = 7'h6F;
      4'hA: hex_font = 7'h77;  4'hB: hex_font = 7'h7C;
      4'hC: hex_font = 7'h39;  4'hD: hex_font = 7'h5E;
      4'hE: hex_font = 7'h79;  default: hex_font = 7'h71;
    endcase
  endfunction

  // Capture is independent of state; OFF only differs in holding the scan at its origin.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shown_d = cpu.out_valid ? cpu.out_data : shown_q;
    case (state_q)
      ST_OFF: begin
        cnt_d = '0;
        idx_d = '0;
        if (cpu.out_valid) state_d = ST_SCAN;
      end
      ST_SCAN: begin
        if (cnt_q == CNT_MAX) begin
          cnt_d = '0;
          idx_d = idx_q + 2'd1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = ST_OFF;
    endcase
  end

  always_comb begin
    nibble = shown_q[4*idx_q +: 4];
    case (idx_q)
      2'd1:    blank = (BLANK_LZ != 0) && (shown_q[15:4]  == 12'h000);
      2'd2:    blank = (BLANK_LZ != 0) && (shown_q[15:8]  == 8'h00);
      2'd3:    blank = (BLANK_LZ != 0) && (shown_q[15:12] == 4'h0);
      default: blank = 1'b0;
    endcase
    lit  = (state_q == ST_SCAN) && (cnt_q >= CNT_GUARD) && !blank;
    seg_d = (lit ? hex_font(nibble) : 7'h00) ^ SEG_OFF;
    an_d  = (lit ? (4'b0001 << idx_q) : 4'b0000) ^ AN_OFF;
    dp_d  = (lit && (idx_q == 2'd0) && cpu.halted) ^ POL;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_OFF;
      cnt_q   <= '0;
      idx_q   <= '0;
      shown_q <= '0;
      seg_q   <= SEG_OFF;
      dp_q    <= POL;
      an_q    <= AN_OFF;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shown_q <= shown_d;
      seg_q   <= seg_d;
      dp_q    <= dp_d;
      an_q    <= an_d;
    end
  end

  assign seg   = seg_q;
  assign dp    = dp_q;
  assign an    = an_q;
  assign shown = shown_q;

endmodule
`default_nettype wire

// File: tb/tb_seg7_scan_display.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_seg7_scan_display: directed bench for the 7-segment scanner   |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module tb_seg7_scan_display;

  logic        clk;
  logic        rst_n;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  an;
  logic [15:0] shown;

  int chk_total = 0;
  int chk_pass  = 0;
  int chk_fail  = 0;
  int p         = 0;   // cycles since the capture that left OFF

  seg7_scan_display_if cpu_if ();

  seg7_scan_display #(
    .REFRESH_DIV (8),
    .GUARD       (2),
    .BLANK_LZ    (1),
    .ACTIVE_LOW  (1)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .cpu   (cpu_if.slave),
    .seg   (seg),
    .dp    (dp),
    .an    (an),
    .shown (shown)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    chk_total++;
    assert (obs === exp) chk_pass++;
    else begin
      chk_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      p++;
    end
  endtask

  // Tables hold per-digit expectations while lit; a blanked digit carries an=F, seg=7F.
  task automatic scan_check(input string tag, input logic [15:0] an_t,
                            input logic [27:0] seg_t, input logic [3:0] dp_t);
    int s, c, d;
    logic [3:0] e_an;
    logic [6:0] e_seg;
    logic       e_dp;
    for (int k = 0; k < 32; k++) begin
      step(1);
      s = p - 1;
      c = s % 8;
      d = (s / 8) % 4;
      if (c >= 2) begin
        e_an  = an_t[4*d +: 4];
        e_seg = seg_t[7*d +: 7];
        e_dp  = dp_t[d];
      end else begin
        e_an  = 4'hF;
        e_seg = 7'h7F;
        e_dp  = 1'b1;
      end
      chk($sformatf("%s_an_d%0d_c%0d", tag, d, c), {12'h0, an}, {12'h0, e_an});
      chk($sformatf("%s_seg_d%0d_c%0d", tag, d, c), {9'h0, seg}, {9'h0, e_seg});
      chk($sformatf("%s_dp_d%0d_c%0d", tag, d, c), {15'h0, dp}, {15'h0, e_dp});
    end
  endtask

  task automatic strobe(input logic [15:0] v);
    cpu_if.out_data  = v;
    cpu_if.out_valid = 1'b1;
    step(1);
    cpu_if.out_valid = 1'b0;
  endtask

  initial begin
    int bad;
    rst_n            = 1'b1;
    cpu_if.out_data  = 16'h0;
    cpu_if.out_valid = 1'b0;
    cpu_if.halted    = 1'b0;

    // Reset values, asynchronously and after a clock edge
    #2 rst_n = 1'b0;
    #1;
    chk("rst_an", {12'h0, an}, 16'h000F);
    chk("rst_seg", {9'h0, seg}, 16'h007F);
    chk("rst_dp", {15'h0, dp}, 16'h0001);
    chk("rst_shown", shown, 16'h0000);
    step(2);
    rst_n = 1'b1;
    step(1);
    chk("rst_an_after_edge", {12'h0, an}, 16'h000F);

    // Idle: dark until first strobe
    bad = 0;
    for (int k = 0; k < 100; k++) begin
      step(1);
      if (an !== 4'hF) bad++;
    end
    chk("idle_lit_cycles", bad[15:0], 16'h0000);

    // First capture from OFF
    strobe(16'h1A3F);
    p = 0;
    chk("cap_1a3f_shown", shown, 16'h1A3F);
    scan_check("s1a3f", {4'h7, 4'hB, 4'hD, 4'hE},
               {7'h79, 7'h08, 7'h30, 7'h0E}, 4'hF);

    // Leading-zero blanking
    strobe(16'h0005);
    chk("cap_0005_shown", shown, 16'h0005);
    scan_check("s0005", {4'hF, 4'hF, 4'hF, 4'hE},
               {7'h7F, 7'h7F, 7'h7F, 7'h12}, 4'hF);
    strobe(16'h0000);
    scan_check("s0000", {4'hF, 4'hF, 4'hF, 4'hE},
               {7'h7F, 7'h7F, 7'h7F, 7'h40}, 4'hF);

    // Halt indicator on digit 0
    cpu_if.halted = 1'b1;
    strobe(16'h0042);
    scan_check("s0042h", {4'hF, 4'hF, 4'hD, 4'hE},
               {7'h7F, 7'h7F, 7'h19, 7'h24}, 4'b1110);
    while (((p - 1) % 32) != 3) step(1);
    chk("halt_dp_on", {15'h0, dp}, 16'h0000);
    cpu_if.halted = 1'b0;
    step(1);
    chk("halt_dp_off_an", {12'h0, an}, 16'h000E);
    chk("halt_dp_off", {15'h0, dp}, 16'h0001);

    // Capture on the idx 3 -> 0 wrap edge
    while ((p % 32) != 31) step(1);
    strobe(16'hBEEF);
    chk("wrap_shown", shown, 16'hBEEF);
    scan_check("sbeef", {4'h7, 4'hB, 4'hD, 4'hE},
               {7'h03, 7'h06, 7'h06, 7'h0E}, 4'hF);

    // Back-to-back strobes: last one wins
    strobe(16'h1111);
    strobe(16'h2222);
    chk("b2b_shown", shown, 16'h2222);

    // Mid-scan reset drops everything at once and parks in OFF
    while (((p - 1) % 32) != 4) step(1);
    chk("pre_rst_lit", {12'h0, an}, 16'h000E);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_an", {12'h0, an}, 16'h000F);
    chk("mid_rst_seg", {9'h0, seg}, 16'h007F);
    chk("mid_rst_dp", {15'h0, dp}, 16'h0001);
    chk("mid_rst_shown", shown, 16'h0000);
    step(1);
    rst_n = 1'b1;
    bad = 0;
    for (int k = 0; k < 20; k++) begin
      step(1);
      if (an !== 4'hF) bad++;
    end
    chk("post_rst_off", bad[15:0], 16'h0000);

    $display("%0d/%0d checks passed", chk_pass, chk_total);
    $finish;
  end

endmodule
`default_nettype wire
